// File: rtl/aixh_mxc_left_ospe_ctrl_pkg.sv
// Shared types for the MxConv left-tile ospe drain controller.
// Precision encoding, scale entry width and lane helpers.
`ifndef AIXH_MXC_LOSPE_STAGES
`define AIXH_MXC_LOSPE_STAGES 4
`endif

package AIXH_MXC_pkg;

    localparam int SCALE_BITS = 32;

    typedef enum logic [1:0] {
        P4  = 2'b00,
        P8  = 2'b01,
        P16 = 2'b10
    } prec_e;

    function automatic prec_e prec_decode(logic [1:0] m);
        return (m == 2'b00) ? P4 : (m == 2'b01) ? P8 : P16;
    endfunction

    function automatic logic [3:0] lanes_per_word(prec_e p);
        return (p == P4) ? 4'd8 : (p == P8) ? 4'd4 : 4'd2;
    endfunction

endpackage

// File: rtl/aixh_mxc_left_ospe_pack.sv
// Packs quantized ospe results into 32-bit words.
// Holds the output register; everything moves only on adv.
module aixh_mxc_left_ospe_pack
    import AIXH_MXC_pkg::*;
(
    input  logic        aixh_core_clk2x,
    input  logic        aixh_core_rstn2x,
    input  logic        adv,
    input  prec_e       prec,
    input  logic        res_valid,
    input  logic        res_last,
    input  logic [15:0] res_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last
);

    logic [2:0]  lane_q;
    logic [31:0] buf_q;
    logic [31:0] ins;
    logic [31:0] word;
    logic        lane_full;
    logic        word_done;

    always_comb begin
        ins = '0;
        unique case (prec)
            P4:      ins = 32'(res_data[3:0]) << {lane_q, 2'b00};
            P8:      ins = 32'(res_data[7:0]) << {lane_q, 3'b000};
            default: ins = 32'(res_data) << {lane_q, 4'b0000};
        endcase
    end

    assign word      = buf_q | ins;
    assign lane_full = (lane_q == 3'(lanes_per_word(prec) - 4'd1));
    assign word_done = res_valid && (lane_full || res_last);

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            lane_q    <= '0;
            buf_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            // adv implies the held word (if any) was taken this cycle
            out_valid <= word_done;
            if (word_done) begin
                out_data <= word;
                out_last <= res_last;
                buf_q    <= '0;
                lane_q   <= '0;
            end else if (res_valid) begin
                buf_q    <= word;
                lane_q   <= lane_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/aixh_mxc_left_ospe_ctrl.sv
// Left-tile ospe drain controller: issues accumulator and padding
// slots, tracks ospe latency with tags and packs the results.
module aixh_mxc_left_ospe_ctrl
    import AIXH_MXC_pkg::*;
#(
    parameter int OSPE_LAT      = `AIXH_MXC_LOSPE_STAGES,
    parameter int SCALE_ENTRIES = 64,
    parameter int CNT_BITS      = 16
) (
    input  logic                             aixh_core_clk2x,
    input  logic                             aixh_core_rstn2x,
    input  logic                             scl_we,
    input  logic [$clog2(SCALE_ENTRIES)-1:0] scl_addr,
    input  logic [SCALE_BITS-1:0]            scl_wdata,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [CNT_BITS-1:0]              cmd_total,
    input  logic [CNT_BITS-1:0]              cmd_active,
    input  logic [1:0]                       cmd_prec,
    input  logic                             cmd_uint,
    input  logic [$clog2(SCALE_ENTRIES)-1:0] cmd_scl_base,
    input  logic                             acc_valid,
    output logic                             acc_ready,
    input  logic [47:0]                      acc_data,
    output logic                             ospe_enable,
    output logic                             ospe_nullify,
    output logic [1:0]                       ospe_prec_mode,
    output logic                             ospe_uint_mode,
    output logic [SCALE_BITS-1:0]            ospe_isdata,
    output logic [47:0]                      ospe_imdata,
    input  logic [15:0]                      ospe_owdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_data,
    output logic                             out_last,
    output logic                             busy
);

    localparam int AW = $clog2(SCALE_ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_BITS-1:0]   total_q;
    logic [CNT_BITS-1:0]   active_q;
    logic [CNT_BITS-1:0]   idx_q;
    logic [CNT_BITS-1:0]   idx_d;
    logic [AW-1:0]         base_q;
    logic [AW-1:0]         scl_idx;
    logic [OSPE_LAT-1:0]   tags_q;
    logic [OSPE_LAT-1:0]   lasts_q;
    logic [SCALE_BITS-1:0] scl_tab [SCALE_ENTRIES];

    logic  adv;
    logic  cmd_fire;
    logic  slot_tag;
    logic  slot_data;
    logic  slot_pad;
    logic  slot_last;
    prec_e prec;

    assign adv         = !out_valid || out_ready;
    assign ospe_enable = adv;
    assign cmd_fire    = cmd_valid && cmd_ready;
    assign slot_last   = (idx_q == total_q - CNT_BITS'(1));
    assign scl_idx     = base_q + idx_q[AW-1:0];
    assign busy        = (state_q != S_IDLE);
    assign prec        = prec_decode(ospe_prec_mode);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_ready = 1'b0;
        acc_ready = 1'b0;
        slot_tag  = 1'b0;
        slot_data = 1'b0;
        slot_pad  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = adv;
                if (adv && cmd_valid) begin
                    state_d = S_ISSUE;
                    idx_d   = '0;
                end
            end
            S_ISSUE: begin
                if (adv) begin
                    if (idx_q < active_q) begin
                        acc_ready = 1'b1;
                        slot_data = acc_valid;
                        slot_tag  = acc_valid;
                    end else begin
                        slot_pad  = 1'b1;
                        slot_tag  = 1'b1;
                    end
                    if (slot_tag) begin
                        idx_d = idx_q + CNT_BITS'(1);
                        if (slot_last) state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (adv && tags_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            state_q        <= S_IDLE;
            total_q        <= '0;
            active_q       <= '0;
            base_q         <= '0;
            idx_q          <= '0;
            tags_q         <= '0;
            lasts_q        <= '0;
            ospe_imdata    <= '0;
            ospe_isdata    <= '0;
            ospe_nullify   <= 1'b0;
            ospe_prec_mode <= '0;
            ospe_uint_mode <= 1'b0;
        end else if (adv) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tags_q  <= (tags_q << 1) | OSPE_LAT'(slot_tag);
            lasts_q <= (lasts_q << 1) | OSPE_LAT'(slot_tag && slot_last);
            if (cmd_fire) begin
                total_q        <= cmd_total;
                active_q       <= cmd_active;
                base_q         <= cmd_scl_base;
                ospe_prec_mode <= cmd_prec;
                ospe_uint_mode <= cmd_uint;
            end
            if (state_q == S_ISSUE) ospe_isdata <= scl_tab[scl_idx];
            // bubbles leave the ospe inputs untouched
            if (slot_data) begin
                ospe_imdata  <= acc_data;
                ospe_nullify <= 1'b0;
            end else if (slot_pad) begin
                ospe_imdata  <= '0;
                ospe_nullify <= 1'b1;
            end
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (scl_we) scl_tab[scl_addr] <= scl_wdata;
    end

    aixh_mxc_left_ospe_pack u_pack (
        .aixh_core_clk2x  (aixh_core_clk2x),
        .aixh_core_rstn2x (aixh_core_rstn2x),
        .adv              (adv),
        .prec             (prec),
        .res_valid        (tags_q[OSPE_LAT-1]),
        .res_last         (lasts_q[OSPE_LAT-1]),
        .res_data         (ospe_owdata),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_last         (out_last)
    );

endmodule
